uart_tx_arbiter: RTL and testbench

Shares the single UART transmit line among several on-chip requesters. Each requester offers a byte over a valid/ready handshake. A round-robin arbiter picks one requester per frame, and an 8N1 framing engine with an internal baud divider serialises the byte onto `serial_tx`. The block sits between the console/debug sources and the board TX pin and replaces the free-running TX shift path.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int unsigned CLOCK_HZ      = 1_000_000;
   localparam int unsigned BAUD_HZ       = 9_600;
   // Rounded to the nearest whole cycle count per bit.
   localparam int unsigned CLOCK_DIV_MAX = (CLOCK_HZ + BAUD_HZ / 2) / BAUD_HZ - 1;
   localparam int unsigned FRAME_BITS    = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLOCK_DIV_MAX while enabled, pulses tick at the terminal count.
module uart_baud_tick #(
   parameter int unsigned CLOCK_DIV_MAX = uart_pkg::CLOCK_DIV_MAX
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = (CLOCK_DIV_MAX > 0) ? $clog2(CLOCK_DIV_MAX + 1) : 1;

   logic [CW-1:0] r_count;
   logic          w_terminal;

   assign w_terminal = (r_count == CW'(CLOCK_DIV_MAX));
   assign tick       = enable && w_terminal;

   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         r_count <= '0;
      end else if (w_terminal) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding an 8N1 transmit engine; one requester is served per frame.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned CLOCK_DIV_MAX = uart_pkg::CLOCK_DIV_MAX
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       serial_tx,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   import uart_pkg::*;

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   uart_state_t       r_state;
   logic              r_tx;
   logic              r_busy;
   logic [ID_W-1:0]   r_grant;
   logic [7:0]        r_shift;
   logic [2:0]        r_bit;

   logic              w_tick;
   logic              w_baud_en;
   logic              w_found;
   logic              w_hs;
   logic [ID_W-1:0]   w_sel;
   logic [ID_W-1:0]   w_idx;
   logic [7:0]        w_byte;
   logic [NUM_REQ-1:0] w_ready;

   assign w_baud_en = (r_state != IDLE);

   uart_baud_tick #(
      .CLOCK_DIV_MAX(CLOCK_DIV_MAX)
   ) u_baud_tick (
      .clock (clock),
      .reset (reset),
      .enable(w_baud_en),
      .tick  (w_tick)
   );

   // Search starts just past the last winner, so it drops to lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      w_byte  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_W'((32'(r_grant) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_sel   = w_idx;
            w_byte  = req_data[8*32'(w_idx) +: 8];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (r_state == IDLE && w_found) begin
         w_ready[w_sel] = 1'b1;
      end
   end

   assign w_hs      = |(req_valid & w_ready);
   assign req_ready = w_ready;
   assign serial_tx = r_tx;
   assign busy      = r_busy;
   assign grant_id  = r_grant;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_grant <= ID_W'(NUM_REQ - 1);
         r_shift <= '0;
         r_bit   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_shift <= w_byte;
                  r_grant <= w_sel;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_tick) begin
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and CLOCK_DIV_MAX=3 (4 cycles per bit).
module tb_uart_tx_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        serial_tx;
   logic        busy;
   logic [1:0]  grant_id;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   uart_tx_arbiter #(
      .NUM_REQ      (4),
      .CLOCK_DIV_MAX(3)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .serial_tx(serial_tx),
      .busy     (busy),
      .grant_id (grant_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level c cycles after the handshake cycle, for a 4-cycle bit time.
   function automatic logic exp_tx(input logic [7:0] b, input int c);
      int s;
      s = (c - 1) / 4;
      if (s == 0) return 1'b0;
      else if (s <= 8) return b[s-1];
      else return 1'b1;
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
   endtask

   // Entered in handshake cycle T; returns at T+41 (2 time units after the edge).
   task automatic run_frame(input logic [7:0] b, input logic [1:0] id, input logic [3:0] drop,
                            input int set_c, input logic [3:0] set_m,
                            input int clr_c, input logic [3:0] clr_m);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         if (c == 1) req_valid = req_valid & ~drop;
         if (c == set_c) req_valid = req_valid | set_m;
         if (c == clr_c) req_valid = req_valid & ~clr_m;
         #1;
         check($sformatf("tx byte %0h cycle %0d", b, c), {31'd0, serial_tx}, {31'd0, exp_tx(b, c)});
         check($sformatf("busy cycle %0d", c), {31'd0, busy}, 32'd1);
         check($sformatf("ready blocked cycle %0d", c), {28'd0, req_ready}, 32'd0);
         if (c == 1) check("grant_id", {30'd0, grant_id}, {30'd0, id});
      end
      @(posedge clock);
      #2;
      check("busy after frame", {31'd0, busy}, 32'd0);
      check("tx idle after frame", {31'd0, serial_tx}, 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;

      do_reset();
      check("reset tx", {31'd0, serial_tx}, 32'd1);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset ready", {28'd0, req_ready}, 32'd0);
      check("reset grant", {30'd0, grant_id}, 32'd3);

      // Single byte 0x55 from requester 0
      req_data[7:0] = 8'h55;
      req_valid     = 4'b0001;
      #1;
      check("s1 ready", {28'd0, req_ready}, 32'h1);
      run_frame(8'h55, 2'd0, 4'b0001, 0, 4'b0000, 0, 4'b0000);
      check("s1 grant", {30'd0, grant_id}, 32'd0);

      // Contention between requesters 1 and 2
      do_reset();
      req_data[15:8]  = 8'hA1;
      req_data[23:16] = 8'hB2;
      req_valid       = 4'b0110;
      #1;
      check("s2 ready first", {28'd0, req_ready}, 32'h2);
      run_frame(8'hA1, 2'd1, 4'b0010, 0, 4'b0000, 0, 4'b0000);
      check("s2 ready second", {28'd0, req_ready}, 32'h4);
      run_frame(8'hB2, 2'd2, 4'b0100, 0, 4'b0000, 0, 4'b0000);

      // Requester 3 arrives mid-frame and waits until T+41
      req_data[15:8]  = 8'h5A;
      req_data[31:24] = 8'hC3;
      req_valid       = 4'b0010;
      #1;
      check("s4 ready req1", {28'd0, req_ready}, 32'h2);
      run_frame(8'h5A, 2'd1, 4'b0010, 5, 4'b1000, 0, 4'b0000);
      check("s4 ready req3", {28'd0, req_ready}, 32'h8);
      run_frame(8'hC3, 2'd3, 4'b1000, 0, 4'b0000, 0, 4'b0000);

      // Requester 2 pulses valid for one cycle during a frame
      req_data[7:0] = 8'h0F;
      req_valid     = 4'b0001;
      #1;
      check("s6 ready req0", {28'd0, req_ready}, 32'h1);
      run_frame(8'h0F, 2'd0, 4'b0001, 10, 4'b0100, 11, 4'b0100);
      check("s6 no ready", {28'd0, req_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #2;
         check($sformatf("s6 idle busy %0d", i), {31'd0, busy}, 32'd0);
         check($sformatf("s6 idle tx %0d", i), {31'd0, serial_tx}, 32'd1);
      end
      check("s6 grant", {30'd0, grant_id}, 32'd0);

      // All four requesters held valid: order 0,1,2,3,0 at 41-cycle spacing
      do_reset();
      req_data  = 32'h8844_2211;
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         logic [1:0] g;
         logic [7:0] b;
         logic [31:0] d;
         g = 2'(k % 4);
         d = req_data;
         b = d[8*g +: 8];
         check($sformatf("s3 ready turn %0d", k), {28'd0, req_ready}, 32'd1 << g);
         run_frame(b, g, 4'b0000, 0, 4'b0000, 0, 4'b0000);
      end
      req_valid = '0;

      // Reset during DATA aborts the frame
      do_reset();
      req_data[7:0] = 8'h00;
      req_valid     = 4'b0001;
      #1;
      check("s5 ready", {28'd0, req_ready}, 32'h1);
      for (int c = 1; c <= 17; c++) begin
         @(posedge clock);
         #1;
         if (c == 1) req_valid = '0;
         #1;
         check($sformatf("s5 tx cycle %0d", c), {31'd0, serial_tx}, {31'd0, exp_tx(8'h00, c)});
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("s5 tx after reset", {31'd0, serial_tx}, 32'd1);
      check("s5 busy after reset", {31'd0, busy}, 32'd0);
      check("s5 grant after reset", {30'd0, grant_id}, 32'd3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #2;
         check($sformatf("s5 tx hold %0d", i), {31'd0, serial_tx}, 32'd1);
         check($sformatf("s5 busy hold %0d", i), {31'd0, busy}, 32'd0);
      end
      req_data[7:0] = 8'h3C;
      req_valid     = 4'b0001;
      #1;
      check("s5 ready new", {28'd0, req_ready}, 32'h1);
      run_frame(8'h3C, 2'd0, 4'b0001, 0, 4'b0000, 0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
